// File: rtl/clock_pkg.sv
// Shared widths, limits and edit-state encoding for the alarm clock blocks.
// Also holds the wrap-around step helpers used by the alarm editor.
package clock_pkg;

  localparam int unsigned MIN_W    = 6;
  localparam int unsigned HOUR_W   = 5;
  localparam int unsigned MAX_MIN  = 59;
  localparam int unsigned MAX_HOUR = 23;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StEditH  = 2'b01,
    StEditM  = 2'b10,
    StCommit = 2'b11
  } edit_state_e;

  function automatic logic [HOUR_W-1:0] hour_step(input logic [HOUR_W-1:0] h, input logic up);
    if (up) return (h == HOUR_W'(MAX_HOUR)) ? '0 : h + HOUR_W'(1);
    return (h == '0) ? HOUR_W'(MAX_HOUR) : h - HOUR_W'(1);
  endfunction

  function automatic logic [MIN_W-1:0] min_step(input logic [MIN_W-1:0] m, input logic up);
    if (up) return (m == MIN_W'(MAX_MIN)) ? '0 : m + MIN_W'(1);
    return (m == '0) ? MIN_W'(MAX_MIN) : m - MIN_W'(1);
  endfunction

endpackage

// File: rtl/button_repeat.sv
// Rising-edge step generator with hold-to-repeat for a debounced button level.
// A button held through reset stays silent until released and pressed again.
module button_repeat #(
  parameter int unsigned REPEAT_DELAY = 25_000_000,
  parameter int unsigned REPEAT_RATE  = 5_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic step_o
);

  logic        prev_q;
  logic        armed_q;
  logic        repeating_q;
  logic [31:0] cnt_q;
  logic        edge_det;
  logic        rep_hit;

  always_comb begin
    edge_det = btn_i & ~prev_q;
    rep_hit  = armed_q & btn_i &
               (cnt_q == (repeating_q ? 32'(REPEAT_RATE) : 32'(REPEAT_DELAY)));
    step_o   = edge_det | rep_hit;
  end

  // cnt_q holds the number of cycles since the last step while the button is held
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q      <= 1'b1;
      armed_q     <= 1'b0;
      repeating_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      prev_q <= btn_i;
      if (!btn_i) begin
        armed_q     <= 1'b0;
        repeating_q <= 1'b0;
        cnt_q       <= '0;
      end else if (edge_det) begin
        armed_q     <= 1'b1;
        repeating_q <= 1'b0;
        cnt_q       <= 32'd1;
      end else if (rep_hit) begin
        repeating_q <= 1'b1;
        cnt_q       <= 32'd1;
      end else if (armed_q) begin
        cnt_q <= cnt_q + 32'd1;
      end
    end
  end

endmodule

// File: rtl/alarm_set_controller.sv
// Alarm time editor: mode cycles hours -> minutes -> commit; inc/dec step the
// selected field with auto-repeat; idle seconds abandon the edit.
module alarm_set_controller
  import clock_pkg::*;
#(
  parameter int unsigned TIMEOUT_S    = 10,
  parameter int unsigned REPEAT_DELAY = 25_000_000,
  parameter int unsigned REPEAT_RATE  = 5_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick_1hz,
  input  logic              btn_mode,
  input  logic              btn_inc,
  input  logic              btn_dec,
  input  logic [MIN_W-1:0]  alarm_minutes_in,
  input  logic [HOUR_W-1:0] alarm_hours_in,
  output logic [MIN_W-1:0]  new_alarm_minutes,
  output logic [HOUR_W-1:0] new_alarm_hours,
  output logic              set_alarm,
  output logic [1:0]        edit_field
);

  localparam int unsigned TW = (TIMEOUT_S > 1) ? $clog2(TIMEOUT_S) : 1;

  edit_state_e       state_q;
  logic [HOUR_W-1:0] hours_q;
  logic [MIN_W-1:0]  mins_q;
  logic              set_alarm_q;
  logic [TW-1:0]     tmo_q;
  logic              mode_prev_q;
  logic              mode_step;
  logic              inc_step;
  logic              dec_step;

  button_repeat #(
    .REPEAT_DELAY(REPEAT_DELAY),
    .REPEAT_RATE (REPEAT_RATE)
  ) u_inc (
    .clk   (clk),
    .rst   (rst),
    .btn_i (btn_inc),
    .step_o(inc_step)
  );

  button_repeat #(
    .REPEAT_DELAY(REPEAT_DELAY),
    .REPEAT_RATE (REPEAT_RATE)
  ) u_dec (
    .clk   (clk),
    .rst   (rst),
    .btn_i (btn_dec),
    .step_o(dec_step)
  );

  assign mode_step = btn_mode & ~mode_prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      hours_q     <= '0;
      mins_q      <= '0;
      set_alarm_q <= 1'b0;
      tmo_q       <= '0;
      mode_prev_q <= 1'b1;
    end else begin
      mode_prev_q <= btn_mode;
      set_alarm_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (mode_step) begin
            state_q <= StEditH;
            hours_q <= (alarm_hours_in > HOUR_W'(MAX_HOUR)) ? '0 : alarm_hours_in;
            mins_q  <= (alarm_minutes_in > MIN_W'(MAX_MIN)) ? '0 : alarm_minutes_in;
            tmo_q   <= '0;
          end
        end
        StEditH, StEditM: begin
          if (mode_step) begin
            tmo_q <= '0;
            if (state_q == StEditH) begin
              state_q <= StEditM;
            end else begin
              state_q     <= StCommit;
              set_alarm_q <= 1'b1;
            end
          end else if (inc_step || dec_step) begin
            // Simultaneous inc and dec cancel but still count as activity
            tmo_q <= '0;
            if (inc_step ^ dec_step) begin
              if (state_q == StEditH) hours_q <= hour_step(hours_q, inc_step);
              else                    mins_q  <= min_step(mins_q, inc_step);
            end
          end else if (tick_1hz) begin
            if (tmo_q == TW'(TIMEOUT_S - 1)) begin
              state_q <= StIdle;
              tmo_q   <= '0;
            end else begin
              tmo_q <= tmo_q + TW'(1);
            end
          end
        end
        StCommit: state_q <= StIdle;
        default:  state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    case (state_q)
      StEditH: edit_field = 2'b01;
      StEditM: edit_field = 2'b10;
      default: edit_field = 2'b00;
    endcase
  end

  assign new_alarm_hours   = hours_q;
  assign new_alarm_minutes = mins_q;
  assign set_alarm         = set_alarm_q;

endmodule

// File: tb/tb_alarm_set_controller.sv
// Randomized and directed bench for alarm_set_controller against a
// cycle-level behavioural model of the editing rules.
module tb_alarm_set_controller;

  localparam int unsigned TO = 10;
  localparam int unsigned RD = 10;
  localparam int unsigned RR = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic       bm, bi, bd;
  logic [5:0] min_in;
  logic [4:0] hr_in;
  logic [5:0] new_min;
  logic [4:0] new_hr;
  logic       set_al;
  logic [1:0] field;

  int n_checks = 0;
  int n_pass   = 0;
  int sa_cnt   = 0;

  // Model: 0 idle, 1 editing hours, 2 editing minutes, 3 commit
  int m_st, m_h, m_m, m_t;
  bit pm, pi, pd;
  int li, ld;

  always #5 clk = ~clk;

  alarm_set_controller #(
    .TIMEOUT_S   (TO),
    .REPEAT_DELAY(RD),
    .REPEAT_RATE (RR)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .tick_1hz         (tick),
    .btn_mode         (bm),
    .btn_inc          (bi),
    .btn_dec          (bd),
    .alarm_minutes_in (min_in),
    .alarm_hours_in   (hr_in),
    .new_alarm_minutes(new_min),
    .new_alarm_hours  (new_hr),
    .set_alarm        (set_al),
    .edit_field       (field)
  );

  task automatic check_eq(input string tag, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
  endtask

  task automatic model_reset();
    m_st = 0; m_h = 0; m_m = 0; m_t = 0;
    pm = 1; pi = 1; pd = 1;
    li = -1; ld = -1;
  endtask

  // len = cycles held since the press edge, -1 when no press is being tracked
  task automatic btn_model(input bit b, input bit p, input int len_in,
                           output bit st, output int len_out);
    st = 0;
    len_out = -1;
    if (b) begin
      if (!p) begin
        len_out = 0;
        st = 1;
      end else if (len_in >= 0) begin
        len_out = len_in + 1;
        st = (len_out >= int'(RD)) && ((len_out - int'(RD)) % int'(RR) == 0);
      end
    end
  endtask

  task automatic model_clk();
    bit ms, si, sd;
    int nli, nld;
    ms = bm && !pm;
    btn_model(bi, pi, li, si, nli);
    btn_model(bd, pd, ld, sd, nld);
    li = nli; ld = nld;
    pm = bm; pi = bi; pd = bd;
    case (m_st)
      0: if (ms) begin
        m_st = 1;
        m_h  = (int'(hr_in) > 23) ? 0 : int'(hr_in);
        m_m  = (int'(min_in) > 59) ? 0 : int'(min_in);
        m_t  = 0;
      end
      1, 2: begin
        if (ms) begin
          m_t = 0;
          m_st = m_st + 1;
        end else if (si || sd) begin
          m_t = 0;
          if (si && !sd) begin
            if (m_st == 1) m_h = (m_h + 1) % 24; else m_m = (m_m + 1) % 60;
          end else if (sd && !si) begin
            if (m_st == 1) m_h = (m_h + 23) % 24; else m_m = (m_m + 59) % 60;
          end
        end else if (tick) begin
          m_t++;
          if (m_t == int'(TO)) begin
            m_st = 0;
            m_t = 0;
          end
        end
      end
      default: m_st = 0;
    endcase
  endtask

  task automatic compare_outputs();
    check_eq("edit_field", int'(field), (m_st == 1) ? 1 : (m_st == 2) ? 2 : 0);
    check_eq("set_alarm", int'(set_al), (m_st == 3) ? 1 : 0);
    check_eq("hours", int'(new_hr), m_h);
    check_eq("minutes", int'(new_min), m_m);
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst) model_reset();
    else model_clk();
    #1;
    if (set_al) sa_cnt++;
    compare_outputs();
  endtask

  task automatic pulse_reset(input int n);
    rst = 1'b1;
    #1;
    model_reset();
    check_eq("rst_field", int'(field), 0);
    check_eq("rst_set", int'(set_al), 0);
    check_eq("rst_hours", int'(new_hr), 0);
    check_eq("rst_minutes", int'(new_min), 0);
    repeat (n) cycle();
    rst = 1'b0;
  endtask

  // which: 0 mode, 1 inc, 2 dec
  task automatic press(input int which);
    case (which)
      0: bm = 1'b1;
      1: bi = 1'b1;
      default: bd = 1'b1;
    endcase
    cycle();
    bm = 1'b0; bi = 1'b0; bd = 1'b0;
    cycle();
  endtask

  task automatic seed(input int h, input int m);
    hr_in = 5'(h);
    min_in = 6'(m);
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; bm = 1'b0; bi = 1'b0; bd = 1'b0;
    hr_in = '0; min_in = '0;
    model_reset();
    #2;
    check_eq("por_field", int'(field), 0);
    check_eq("por_set", int'(set_al), 0);
    check_eq("por_hours", int'(new_hr), 0);
    repeat (2) cycle();
    rst = 1'b0;
    cycle();

    // 07:30 -> 09:29 with a single commit pulse
    seed(7, 30); sa_cnt = 0;
    press(0); press(1); press(1); press(0); press(2); press(0);
    check_eq("d035_hours", int'(new_hr), 9);
    check_eq("d035_minutes", int'(new_min), 29);
    check_eq("d035_pulses", sa_cnt, 1);
    check_eq("d035_field", int'(field), 0);

    // Wrap-arounds at both ends
    seed(23, 59);
    press(0); press(1); press(0); press(1); press(0);
    check_eq("d036_up_hours", int'(new_hr), 0);
    check_eq("d036_up_minutes", int'(new_min), 0);
    seed(0, 0);
    press(0); press(2); press(0); press(2); press(0);
    check_eq("d036_dn_hours", int'(new_hr), 23);
    check_eq("d036_dn_minutes", int'(new_min), 59);

    // Out-of-range seed loads zero
    seed(31, 63);
    press(0);
    check_eq("d037_field", int'(field), 1);
    check_eq("d037_hours", int'(new_hr), 0);
    check_eq("d037_minutes", int'(new_min), 0);

    // Timeout in minutes field without commit
    press(0); sa_cnt = 0;
    for (int i = 0; i < int'(TO); i++) begin
      if (i == int'(TO) - 1) check_eq("d038_before", int'(field), 2);
      tick = 1'b1; cycle(); tick = 1'b0; cycle(); cycle();
    end
    check_eq("d038_field", int'(field), 0);
    check_eq("d038_pulses", sa_cnt, 0);

    // Auto-repeat: 05 held 30 cycles -> 11
    seed(5, 0);
    press(0);
    bi = 1'b1;
    repeat (30) cycle();
    bi = 1'b0;
    cycle();
    check_eq("d039_hours", int'(new_hr), 11);

    // Reset in minutes field with mode held across release
    press(0);
    bm = 1'b1; sa_cnt = 0;
    pulse_reset(2);
    repeat (4) cycle();
    check_eq("d040_field", int'(field), 0);
    check_eq("d040_hours", int'(new_hr), 0);
    check_eq("d040_minutes", int'(new_min), 0);
    check_eq("d040_pulses", sa_cnt, 0);
    bm = 1'b0; cycle();
    bm = 1'b1; cycle();
    check_eq("d040_repress", int'(field), 1);
    bm = 1'b0; cycle();

    // Randomized traffic; odd segments press less often so timeouts occur
    for (int seg = 0; seg < 8; seg++) begin
      int pr;
      pr = (seg % 2 == 1) ? 150 : 18;
      seed(int'($urandom_range(0, 31)), int'($urandom_range(0, 63)));
      for (int c = 0; c < 400; c++) begin
        if ($urandom_range(0, 29) == 0) bm = ~bm;
        if ($urandom_range(0, pr) == 0) bi = ~bi;
        if ($urandom_range(0, pr) == 0) bd = ~bd;
        tick = ($urandom_range(0, 5) == 0);
        if ($urandom_range(0, 40) == 0)
          seed(int'($urandom_range(0, 31)), int'($urandom_range(0, 63)));
        if ($urandom_range(0, 599) == 0) pulse_reset(1);
        else cycle();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
